// File: rtl/block_ram_pkg.sv
// block_ram_pkg: shared types and default geometry for the block_ram slice.
// DEFAULT_MADDR_WIDTH / DEFAULT_MDATA_WIDTH may be predefined by the build.
`timescale 1ns/1ps

`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 16
`endif

`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 16
`endif

package block_ram_pkg;

   localparam int DEF_MADDR_WIDTH = `DEFAULT_MADDR_WIDTH;
   localparam int DEF_MDATA_WIDTH = `DEFAULT_MDATA_WIDTH;
   localparam int DEF_DEPTH       = 256;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_CLEAR = 2'd3
   } ram_state_e;

   // Word-address width; never below one bit so a 1-deep RAM still elaborates.
   function automatic int addr_bits(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/block_ram_array.sv
// block_ram_array: single-port synchronous storage with registered read data.
// The read register only loads when re_i is high so the caller can freeze
// the returned word for as long as it likes.
`timescale 1ns/1ps

module block_ram_array #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 256,
   parameter int AW         = 8
) (
   input  logic                  clock_i,
   input  logic                  we_i,
   input  logic                  re_i,
   input  logic [AW-1:0]         addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Storage write and enabled read register; no reset so it maps onto BRAM.
   always_ff @(posedge clock_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/block_ram.sv
// block_ram: single-port word RAM behind an enable/ready handshake with a
// shared tri-state data bus. The RAM drives mem_data only while returning
// read data and never while mem_write_enable is high.
// Optional feature macro: BLOCK_RAM_CLEAR_ON_RESET_EN -- zero the whole array
// one word per clock after every reset before accepting requests.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for a request; write wins if both enables are high
//   ST_WRITE | word committed on entry, write_ready held until enable drops
//   ST_READ  | word latched on entry, driven on the bus while requested
//   ST_CLEAR | post-reset sweep writing zero, one word per clock
`timescale 1ns/1ps

module block_ram
   import block_ram_pkg::*;
#(
   parameter int MADDR_WIDTH = DEF_MADDR_WIDTH,
   parameter int MDATA_WIDTH = DEF_MDATA_WIDTH,
   parameter int DEPTH       = DEF_DEPTH
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   mem_read_enable,
   input  logic                   mem_write_enable,
   output logic                   mem_write_ready,
   output logic                   mem_read_ready,
   input  logic [MADDR_WIDTH-1:0] mem_addr,
   inout  logic [MDATA_WIDTH-1:0] mem_data
);

   localparam int AW = addr_bits(DEPTH);

   ram_state_e             state_q, state_d;
   logic                   arr_we;
   logic                   arr_re;
   logic [AW-1:0]          arr_addr;
   logic [MDATA_WIDTH-1:0] arr_wdata;
   logic [MDATA_WIDTH-1:0] arr_rdata;
   logic [AW-1:0]          word_addr;
   logic                   drive_bus;
   logic                   unused_addr_hi;

   // Addresses wrap: only the low AW bits select a word.
   assign word_addr      = mem_addr[AW-1:0];
   assign unused_addr_hi = ^mem_addr[MADDR_WIDTH-1:AW];

`ifdef BLOCK_RAM_CLEAR_ON_RESET_EN
   logic [AW-1:0] clr_cnt_q, clr_cnt_d;

   // Sweep counter runs down from the top word; reset reloads it to restart.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         clr_cnt_q <= AW'(DEPTH - 1);
      end else begin
         clr_cnt_q <= clr_cnt_d;
      end
   end
`endif

   // State register; reset aborts any transfer immediately.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
`ifdef BLOCK_RAM_CLEAR_ON_RESET_EN
         state_q <= ST_CLEAR;
`else
         state_q <= ST_IDLE;
`endif
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and array strobes; storage is touched only on IDLE exits and in CLEAR.
   always_comb begin
      state_d   = state_q;
      arr_we    = 1'b0;
      arr_re    = 1'b0;
      arr_addr  = word_addr;
      arr_wdata = mem_data;
`ifdef BLOCK_RAM_CLEAR_ON_RESET_EN
      clr_cnt_d = clr_cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (mem_write_enable) begin
               arr_we  = 1'b1;
               state_d = ST_WRITE;
            end else if (mem_read_enable) begin
               arr_re  = 1'b1;
               state_d = ST_READ;
            end
         end
         ST_WRITE: begin
            if (!mem_write_enable) begin
               state_d = ST_IDLE;
            end
         end
         ST_READ: begin
            if (!mem_read_enable || mem_write_enable) begin
               state_d = ST_IDLE;
            end
         end
`ifdef BLOCK_RAM_CLEAR_ON_RESET_EN
         ST_CLEAR: begin
            arr_we    = 1'b1;
            arr_addr  = clr_cnt_q;
            arr_wdata = '0;
            if (clr_cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               clr_cnt_d = clr_cnt_q - 1'b1;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // A write request arriving mid-read releases the bus and read_ready at once.
   assign mem_write_ready = (state_q == ST_WRITE);
   assign mem_read_ready  = (state_q == ST_READ) && !mem_write_enable;
   assign drive_bus       = (state_q == ST_READ) && mem_read_enable && !mem_write_enable;
   assign mem_data        = drive_bus ? arr_rdata : {MDATA_WIDTH{1'bz}};

   block_ram_array #(
      .DATA_WIDTH (MDATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (AW)
   ) u_array (
      .clock_i (clock),
      .we_i    (arr_we),
      .re_i    (arr_re),
      .addr_i  (arr_addr),
      .wdata_i (arr_wdata),
      .rdata_o (arr_rdata)
   );

endmodule

// File: tb/tb_block_ram.sv
// tb_block_ram: handshake, bus-release, wrap and reset behaviour of block_ram,
// with random traffic checked against a word array indexed by address % DEPTH.
// The bus is a pulled-up net, so an undriven bus reads as all ones.
`timescale 1ns/1ps

module tb_block_ram;

   localparam int AWB   = 16;
   localparam int DW    = 16;
   localparam int DEPTH = 256;
   localparam logic [DW-1:0] FLOAT = '1;

   logic           clock = 1'b0;
   logic           reset = 1'b1;
   logic           re = 1'b0;
   logic           we = 1'b0;
   logic [AWB-1:0] addr = '0;
   logic           tb_oe = 1'b0;
   logic [DW-1:0]  tb_wdata = '0;
   logic           write_ready;
   logic           read_ready;
   tri1 [DW-1:0]   mem_data;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] model [DEPTH];
   bit            known [DEPTH];

   assign mem_data = tb_oe ? tb_wdata : {DW{1'bz}};

   always #5 clock = ~clock;

   block_ram dut (
      .clock            (clock),
      .reset            (reset),
      .mem_read_enable  (re),
      .mem_write_enable (we),
      .mem_write_ready  (write_ready),
      .mem_read_ready   (read_ready),
      .mem_addr         (addr),
      .mem_data         (mem_data)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // After reset releases: in the clear build the sweep must finish and leave zeros.
   task automatic after_reset();
`ifdef BLOCK_RAM_CLEAR_ON_RESET_EN
      for (int k = 0; k < DEPTH + 2; k++) tick();
      for (int k = 0; k < DEPTH; k++) begin
         model[k] = '0;
         known[k] = 1'b1;
      end
`endif
   endtask

   task automatic do_write(input logic [AWB-1:0] a, input logic [DW-1:0] d, input string tag);
      int n;
      we = 1'b1; addr = a; tb_wdata = d; tb_oe = 1'b1;
      #1;
      checks++;
      if (write_ready !== 1'b0) begin
         errors++; $display("FAIL %s early_wready got=%b want=0", tag, write_ready);
      end
      tick();
      n = 0;
      while (write_ready !== 1'b1 && n < 8) begin tick(); n++; end
      checks++;
      if (write_ready !== 1'b1 || n != 0) begin
         errors++; $display("FAIL %s wready_latency got_extra_cycles=%0d ready=%b want=0,1", tag, n, write_ready);
      end
      we = 1'b0; tb_oe = 1'b0;
      tick();
      checks++;
      if (write_ready !== 1'b0) begin
         errors++; $display("FAIL %s wready_drop got=%b want=0", tag, write_ready);
      end
      model[a % DEPTH] = d;
      known[a % DEPTH] = 1'b1;
   endtask

   task automatic do_read(input logic [AWB-1:0] a, input logic [DW-1:0] exp, input string tag);
      int n;
      re = 1'b1; addr = a;
      #1;
      checks++;
      if (read_ready !== 1'b0 || mem_data !== FLOAT) begin
         errors++; $display("FAIL %s early_rready got=%b/%h want=0/%h", tag, read_ready, mem_data, FLOAT);
      end
      tick();
      n = 0;
      while (read_ready !== 1'b1 && n < 8) begin tick(); n++; end
      checks++;
      if (read_ready !== 1'b1 || n != 0) begin
         errors++; $display("FAIL %s rready_latency got_extra_cycles=%0d ready=%b want=0,1", tag, n, read_ready);
      end
      checks++;
      if (mem_data !== exp) begin
         errors++; $display("FAIL %s rdata addr=%h got=%h want=%h", tag, a, mem_data, exp);
      end
      re = 1'b0;
      #1;
      checks++;
      if (mem_data !== FLOAT) begin
         errors++; $display("FAIL %s bus_release got=%h want=%h", tag, mem_data, FLOAT);
      end
      tick();
      checks++;
      if (read_ready !== 1'b0) begin
         errors++; $display("FAIL %s rready_drop got=%b want=0", tag, read_ready);
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (write_ready !== 1'b0 || read_ready !== 1'b0 || mem_data !== FLOAT) begin
         errors++; $display("FAIL reset_state got=%b%b/%h want=00/%h", write_ready, read_ready, mem_data, FLOAT);
      end
      tick(); tick();
      reset = 1'b0;
      after_reset();
      checks++;
      if (write_ready !== 1'b0 || read_ready !== 1'b0) begin
         errors++; $display("FAIL post_reset_ready got=%b%b want=00", write_ready, read_ready);
      end
   endtask

   task automatic test_write_readback();
      for (int i = 0; i < 10; i++) begin
         do_write(AWB'(i * AWB / 8), DW'(i * i + 5), "wr_loop");
         do_read(AWB'(i * AWB / 8), DW'(i * i + 5), "rd_loop");
      end
   endtask

   task automatic test_both_enables();
      we = 1'b1; re = 1'b1; addr = 16'h0060; tb_wdata = 16'h5A5A; tb_oe = 1'b1;
      #1;
      checks++;
      if (read_ready !== 1'b0 || write_ready !== 1'b0) begin
         errors++; $display("FAIL both_early got=%b%b want=00", write_ready, read_ready);
      end
      tick();
      checks++;
      if (write_ready !== 1'b1 || read_ready !== 1'b0) begin
         errors++; $display("FAIL both_write_wins got=%b%b want=10", write_ready, read_ready);
      end
      tb_oe = 1'b0;
      #1;
      checks++;
      if (mem_data !== FLOAT) begin
         errors++; $display("FAIL both_bus_free got=%h want=%h", mem_data, FLOAT);
      end
      tick();
      checks++;
      if (write_ready !== 1'b1 || read_ready !== 1'b0 || mem_data !== FLOAT) begin
         errors++; $display("FAIL both_hold got=%b%b/%h want=10/%h", write_ready, read_ready, mem_data, FLOAT);
      end
      we = 1'b0; re = 1'b0;
      tick();
      model[16'h0060 % DEPTH] = 16'h5A5A;
      known[16'h0060 % DEPTH] = 1'b1;
      do_read(16'h0060, 16'h5A5A, "both_readback");
   endtask

   task automatic test_read_hold();
      do_write(16'h0040, 16'h1111, "hold_wr_a");
      do_write(16'h0041, 16'h2222, "hold_wr_b");
      re = 1'b1; addr = 16'h0040;
      tick();
      addr = 16'h0041;
      tick();
      checks++;
      if (read_ready !== 1'b1 || mem_data !== 16'h1111) begin
         errors++; $display("FAIL read_addr_ignored got=%b/%h want=1/1111", read_ready, mem_data);
      end
      re = 1'b0;
      tick();
   endtask

   task automatic test_write_abort_read();
      do_write(16'h0050, 16'h3C3C, "abort_wr");
      re = 1'b1; addr = 16'h0050;
      tick();
      checks++;
      if (mem_data !== 16'h3C3C) begin
         errors++; $display("FAIL abort_pre_data got=%h want=3c3c", mem_data);
      end
      we = 1'b1;
      #1;
      checks++;
      if (mem_data !== FLOAT || read_ready !== 1'b0) begin
         errors++; $display("FAIL abort_comb_release got=%h/%b want=%h/0", mem_data, read_ready, FLOAT);
      end
      tb_wdata = 16'h0F0F; tb_oe = 1'b1;
      tick();
      checks++;
      if (write_ready !== 1'b0 || read_ready !== 1'b0) begin
         errors++; $display("FAIL abort_to_idle got=%b%b want=00", write_ready, read_ready);
      end
      tick();
      checks++;
      if (write_ready !== 1'b1 || read_ready !== 1'b0) begin
         errors++; $display("FAIL abort_then_write got=%b%b want=10", write_ready, read_ready);
      end
      we = 1'b0; re = 1'b0; tb_oe = 1'b0;
      tick();
      model[16'h0050 % DEPTH] = 16'h0F0F;
      do_read(16'h0050, 16'h0F0F, "abort_readback");
   endtask

   task automatic test_wrap();
      do_write(AWB'(DEPTH + 3), 16'h00A5, "wrap_wr");
      do_read(16'h0003, 16'h00A5, "wrap_rd");
   endtask

   task automatic test_random();
      logic [AWB-1:0] a;
      logic [DW-1:0]  d;
      for (int k = 0; k < 40; k++) begin
         a = AWB'($urandom_range(0, 1023));
         if (known[a % DEPTH] && $urandom_range(0, 1) == 1) begin
            do_read(a, model[a % DEPTH], "rand_rd");
         end else begin
            d = DW'($urandom_range(0, 16'hFFFE));
            do_write(a, d, "rand_wr");
         end
      end
   endtask

   task automatic test_reset_mid_read();
      do_write(16'h0005, 16'h1234, "rst_wr");
      re = 1'b1; addr = 16'h0005;
      tick();
      checks++;
      if (read_ready !== 1'b1 || mem_data !== 16'h1234) begin
         errors++; $display("FAIL rst_pre_read got=%b/%h want=1/1234", read_ready, mem_data);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (read_ready !== 1'b0 || write_ready !== 1'b0 || mem_data !== FLOAT) begin
         errors++; $display("FAIL rst_async_abort got=%b%b/%h want=00/%h", write_ready, read_ready, mem_data, FLOAT);
      end
      re = 1'b0;
      tick();
      reset = 1'b0;
      after_reset();
      do_read(16'h0005, model[5], "rst_contents");
   endtask

`ifdef BLOCK_RAM_CLEAR_ON_RESET_EN
   task automatic test_clear();
      do_write(16'h0004, 16'h0007, "clr_wr");
      reset = 1'b1;
      tick();
      reset = 1'b0;
      re = 1'b1; addr = 16'h0004;
      for (int k = 0; k < 10; k++) tick();
      checks++;
      if (read_ready !== 1'b0 || write_ready !== 1'b0 || mem_data !== FLOAT) begin
         errors++; $display("FAIL clr_ignores_req got=%b%b/%h want=00/%h", write_ready, read_ready, mem_data, FLOAT);
      end
      re = 1'b0;
      for (int k = 0; k < DEPTH - 8; k++) tick();
      for (int k = 0; k < DEPTH; k++) begin
         model[k] = '0;
         known[k] = 1'b1;
      end
      do_read(16'h0004, 16'h0000, "clr_zeroed");
   endtask
`endif

   initial begin
      for (int k = 0; k < DEPTH; k++) known[k] = 1'b0;
      test_reset();
      test_write_readback();
      test_both_enables();
      test_read_hold();
      test_write_abort_read();
      test_wrap();
      test_random();
      test_reset_mid_read();
`ifdef BLOCK_RAM_CLEAR_ON_RESET_EN
      test_clear();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
